// File: rtl/execute_div_seq_if.sv
// Valid/done divide handshake between the Execute stage (master) and the
// sequential divider (slave).
interface execute_div_seq_if #(
    parameter int WIDTH = 32
) ();
    logic                 valid;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 done;
    logic [2*WIDTH-1:0]   c;

    modport master (output valid, a, b, input  done, c);
    modport slave  (input  valid, a, b, output done, c);
endinterface

// File: rtl/execute_div_seq.sv
// Multi-cycle unsigned radix-2 restoring divider; returns {remainder, quotient}
// on c in the single cycle done is high.
module execute_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    execute_div_seq_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     rem_q,   rem_d;
    logic [WIDTH-1:0]     quo_q,   quo_d;
    logic [WIDTH-1:0]     div_q,   div_d;
    logic [2*WIDTH-1:0]   c_q,     c_d;

    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     rem_step;
    logic [WIDTH-1:0]     quo_step;

    // Shift the next dividend bit into the partial remainder and try to subtract.
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};

    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        rem_step = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_step = {quo_q[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_step    = trial[WIDTH-1:0];
            quo_step[0] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        c_d     = c_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.valid) begin
                    quo_d   = bus.a;
                    div_d   = bus.b;
                    rem_d   = '0;
                    count_d = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!bus.valid) begin
                    // Flush: drop the partial result, leave c untouched.
                    state_d = S_IDLE;
                end else begin
                    rem_d   = rem_step;
                    quo_d   = quo_step;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        c_d     = {rem_step, quo_step};
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            c_q     <= c_d;
        end
    end

    assign bus.done = (state_q == S_DONE);
    assign bus.c    = c_q;

endmodule

// File: tb/tb_execute_div_seq.sv
// Directed bench for execute_div_seq: scoreboard of expected {rem, quo} values
// pushed at issue and popped when done is seen.
module tb_execute_div_seq;

    localparam int WIDTH = 32;

    logic clk;
    logic resetn;

    execute_div_seq_if #(.WIDTH(WIDTH)) bus ();

    execute_div_seq #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] sb[$];
    logic [63:0] last_c;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
    endfunction

    // Called on a negedge: present the request; the next posedge accepts it.
    task automatic start(input logic [31:0] av, input logic [31:0] bv, input bit push);
        bus.valid = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        if (push) sb.push_back(model(av, bv));
    endtask

    // Counts negedges until done, checks latency and result, optionally drops valid.
    task automatic finish_op(input string tag, input int exp_lat, input bit drop);
        int          lat;
        bit          got;
        logic [63:0] exp_c;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.done === 1'b1) got = 1'b1;
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        exp_c = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check({tag, "_c"}, bus.c, exp_c);
        last_c = exp_c;
        if (drop) begin
            bus.valid = 1'b0;
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
            check({tag, "_c_held"}, bus.c, last_c);
        end
    endtask

    initial begin
        int seen;
        resetn    = 1'b0;
        bus.valid = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        last_c    = '0;

        @(negedge clk);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_c", bus.c, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Basic divide; operands scrambled mid-operation must be ignored.
        start(32'd100, 32'd7, 1'b1);
        repeat (5) @(negedge clk);
        bus.a = 32'hCAFE_F00D;
        bus.b = 32'd3;
        finish_op("basic_100_7", 28, 1'b1);
        check("basic_const", last_c, {32'd2, 32'd14});

        // Extreme operands.
        @(negedge clk);
        start(32'hFFFF_FFFF, 32'd1, 1'b1);
        finish_op("max_div_1", 33, 1'b1);
        @(negedge clk);
        start(32'd5, 32'd9, 1'b1);
        finish_op("small_over_big", 33, 1'b1);

        // Divide by zero.
        @(negedge clk);
        start(32'h1234, 32'd0, 1'b1);
        finish_op("div_by_zero", 33, 1'b1);
        check("div_by_zero_const", last_c, {32'h1234, 32'hFFFF_FFFF});

        // Abort after 10 cycles: done must never rise, c must not move.
        @(negedge clk);
        start(32'd100, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        bus.valid = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        check("abort_c_held", bus.c, last_c);
        start(32'd9, 32'd3, 1'b1);
        finish_op("after_abort_9_3", 33, 1'b1);

        // Back-to-back: valid stays high with new operands on the done cycle.
        @(negedge clk);
        start(32'd20, 32'd3, 1'b1);
        finish_op("b2b_first", 33, 1'b0);
        start(32'd50, 32'd5, 1'b1);
        finish_op("b2b_second", 34, 1'b1);
        check("b2b_const", last_c, {32'd0, 32'd10});

        // Reset mid-operation at count 16.
        @(negedge clk);
        start(32'd100, 32'd7, 1'b0);
        repeat (17) @(negedge clk);
        resetn    = 1'b0;
        bus.valid = 1'b0;
        #1;
        check("midreset_done", 64'(bus.done), 64'd0);
        check("midreset_c", bus.c, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("postreset_idle", 64'(bus.done), 64'd0);
        start(32'd21, 32'd4, 1'b1);
        finish_op("after_reset_21_4", 33, 1'b1);
        check("after_reset_const", last_c, {32'd1, 32'd5});

        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
